// File: rtl/median_pkg.sv
// Shared types and constants for the median window loader and its shift register.
// Optional feature macro used by the loader: MEDIAN_WIN_SEQ_EN (window sequence number output).
package median_pkg;

  localparam int MEDIAN_N = 12;
  localparam int DATA_W   = 32;

  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } win_state_t;

endpackage

// File: rtl/median_win_shreg.sv
// N-deep sample shift register with enable; lane 0 is the oldest sample, lane N-1 the newest.
module median_win_shreg #(
  parameter int N      = 12,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                shift_en,
  input  logic [DATA_W-1:0]   shift_in,
  output logic [N*DATA_W-1:0] par_q
);
  import median_pkg::*;

  logic [N*DATA_W-1:0] sh_q;
  logic [N*DATA_W-1:0] sh_d;

  // Shift toward lane 0 and insert the new sample at lane N-1 when enabled.
  always_comb begin
    sh_d = sh_q;
    if (shift_en) begin
      sh_d = {shift_in, sh_q[N*DATA_W-1:DATA_W]};
    end
  end

  // Sample storage with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q <= '0;
    end else begin
      sh_q <= sh_d;
    end
  end

  assign par_q = sh_q;

endmodule

// File: rtl/median_window_loader.sv
// Sliding-window front end for the median/sort network: collects a scalar sample stream
// and presents a registered N-lane window every STRIDE accepted samples once full.
// Optional macro MEDIAN_WIN_SEQ_EN adds a 16-bit win_seq output (window sequence number).
//
// state | meaning
// FILL  | window not yet full; fill counts accepted samples since reset/flush
// RUN   | window full; stride counts accepts between emitted windows
module median_window_loader #(
  parameter int N      = 12,
  parameter int STRIDE = 1,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [DATA_W-1:0]   in_data,
  output logic                in_ready,
  input  logic                flush,
  output logic                win_valid,
  output logic [N*DATA_W-1:0] win_data,
  input  logic                win_ready
`ifdef MEDIAN_WIN_SEQ_EN
  ,
  output logic [15:0]         win_seq
`endif
);
  import median_pkg::*;

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] FILL_LAST   = CW'(N - 1);
  localparam logic [CW-1:0] STRIDE_LAST = CW'(STRIDE - 1);

  win_state_t          state_q, state_d;
  logic [CW-1:0]       fill_q, fill_d;
  logic [CW-1:0]       stride_q, stride_d;
  logic                win_valid_q, win_valid_d;
  logic [N*DATA_W-1:0] win_data_q, win_data_d;

  logic [N*DATA_W-1:0] sh_par;
  logic [N*DATA_W-1:0] sh_post;
  logic                emit_would;
  logic                accept;
  logic                emit;
  logic                xfer;

`ifdef MEDIAN_WIN_SEQ_EN
  logic [15:0] seq_cnt_q, seq_cnt_d;
  logic [15:0] win_seq_q, win_seq_d;
`endif

  median_win_shreg #(
    .N      (N),
    .DATA_W (DATA_W)
  ) u_shreg (
    .clk      (clk),
    .rst      (rst),
    .shift_en (accept),
    .shift_in (in_data),
    .par_q    (sh_par)
  );

  // Window as it will look after this cycle's accept: the output register loads this on emit.
  assign sh_post = {in_data, sh_par[N*DATA_W-1:DATA_W]};

  // State, counters and output register, all synchronously cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FILL;
      fill_q      <= '0;
      stride_q    <= '0;
      win_valid_q <= 1'b0;
      win_data_q  <= '0;
`ifdef MEDIAN_WIN_SEQ_EN
      seq_cnt_q   <= '0;
      win_seq_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      fill_q      <= fill_d;
      stride_q    <= stride_d;
      win_valid_q <= win_valid_d;
      win_data_q  <= win_data_d;
`ifdef MEDIAN_WIN_SEQ_EN
      seq_cnt_q   <= seq_cnt_d;
      win_seq_q   <= win_seq_d;
`endif
    end
  end

  // Next state and counters: flush restarts filling, accepts advance fill or stride.
  always_comb begin
    state_d  = state_q;
    fill_d   = fill_q;
    stride_d = stride_q;
    if (flush) begin
      state_d  = FILL;
      fill_d   = '0;
      stride_d = '0;
    end else if (accept) begin
      case (state_q)
        FILL: begin
          fill_d = fill_q + CW'(1);
          if (fill_q == FILL_LAST) begin
            state_d  = RUN;
            stride_d = '0;
          end
        end
        RUN: begin
          stride_d = (stride_q == STRIDE_LAST) ? '0 : stride_q + CW'(1);
        end
        default: begin
          state_d = FILL;
        end
      endcase
    end
  end

  // Handshakes, emit decision and output-register next values.
  always_comb begin
    emit_would  = (state_q == FILL) ? (fill_q == FILL_LAST) : (stride_q == STRIDE_LAST);
    // Only a window-completing sample has to wait for the output register to drain.
    in_ready    = !rst && !flush && !(emit_would && win_valid_q && !win_ready);
    accept      = in_valid && in_ready;
    emit        = accept && emit_would;
    xfer        = win_valid_q && win_ready;
    win_valid_d = win_valid_q;
    win_data_d  = win_data_q;
    if (emit) begin
      win_valid_d = 1'b1;
      win_data_d  = sh_post;
    end else if (xfer) begin
      win_valid_d = 1'b0;
    end
`ifdef MEDIAN_WIN_SEQ_EN
    seq_cnt_d = seq_cnt_q;
    win_seq_d = win_seq_q;
    if (emit) begin
      win_seq_d = seq_cnt_q;
      seq_cnt_d = seq_cnt_q + 16'd1;
    end
`endif
  end

  assign win_valid = win_valid_q;
  assign win_data  = win_data_q;
`ifdef MEDIAN_WIN_SEQ_EN
  assign win_seq   = win_seq_q;
`endif

endmodule

// File: tb/tb_median_window_loader.sv
// Bench for median_window_loader: two instances (STRIDE 1 and STRIDE 4), directed scenarios
// plus randomized traffic checked against a sample-count based reference model.
module tb_median_window_loader;

  localparam int N = 12;
  localparam int STRIDES [2] = '{1, 4};

  logic              clk;
  logic              rst;
  logic              in_valid  [2];
  logic [31:0]       in_data   [2];
  logic              in_ready  [2];
  logic              flush     [2];
  logic              win_valid [2];
  logic [N*32-1:0]   win_data  [2];
  logic              win_ready [2];
`ifdef MEDIAN_WIN_SEQ_EN
  logic [15:0]       win_seq   [2];
`endif

  int chk_cnt;
  int pass_cnt;

  median_window_loader #(.N(N), .STRIDE(1), .DATA_W(32)) u_dut_s1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid[0]),
    .in_data   (in_data[0]),
    .in_ready  (in_ready[0]),
    .flush     (flush[0]),
    .win_valid (win_valid[0]),
    .win_data  (win_data[0]),
    .win_ready (win_ready[0])
`ifdef MEDIAN_WIN_SEQ_EN
    ,
    .win_seq   (win_seq[0])
`endif
  );

  median_window_loader #(.N(N), .STRIDE(4), .DATA_W(32)) u_dut_s4 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid[1]),
    .in_data   (in_data[1]),
    .in_ready  (in_ready[1]),
    .flush     (flush[1]),
    .win_valid (win_valid[1]),
    .win_data  (win_data[1]),
    .win_ready (win_ready[1])
`ifdef MEDIAN_WIN_SEQ_EN
    ,
    .win_seq   (win_seq[1])
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Windows are decided purely from how many samples were accepted since reset/flush.
  int              m_cnt   [2];
  bit              m_valid [2];
  logic [31:0]     m_hist  [2][N];
  logic [N*32-1:0] m_win   [2];
  logic [15:0]     m_seq   [2];
  logic [15:0]     m_seq_nx[2];
  bit              ma_acc, ma_em, ma_xf;

  function automatic bit m_would_emit(input int i);
    int c;
    c = m_cnt[i] + 1;
    return (c >= N) && (((c - N) % STRIDES[i]) == 0);
  endfunction

  function automatic bit m_ready(input int i);
    return !rst && !flush[i] && !(m_would_emit(i) && m_valid[i] && !win_ready[i]);
  endfunction

  function automatic logic [N*32-1:0] m_flat(input int i);
    logic [N*32-1:0] v;
    for (int k = 0; k < N; k++) v[k*32 +: 32] = m_hist[i][k];
    return v;
  endfunction

  function automatic logic [N*32-1:0] lanes(input int base);
    logic [N*32-1:0] v;
    for (int k = 0; k < N; k++) v[k*32 +: 32] = 32'(base + k);
    return v;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_cnt[i]    = 0;
        m_valid[i]  = 1'b0;
        m_win[i]    = '0;
        m_seq[i]    = '0;
        m_seq_nx[i] = '0;
        for (int k = 0; k < N; k++) m_hist[i][k] = '0;
      end else begin
        ma_acc = in_valid[i] && m_ready(i);
        ma_em  = ma_acc && m_would_emit(i);
        ma_xf  = m_valid[i] && win_ready[i];
        if (flush[i]) m_cnt[i] = 0;
        if (ma_acc) begin
          for (int k = 0; k < N - 1; k++) m_hist[i][k] = m_hist[i][k+1];
          m_hist[i][N-1] = in_data[i];
          m_cnt[i]++;
        end
        if (ma_em) begin
          m_win[i]    = m_flat(i);
          m_valid[i]  = 1'b1;
          m_seq[i]    = m_seq_nx[i];
          m_seq_nx[i] = m_seq_nx[i] + 16'd1;
        end else if (ma_xf) begin
          m_valid[i] = 1'b0;
        end
      end
    end
  end

  // ---------------- helpers (no checking) ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input int i, input logic v, input logic [31:0] d, input logic f, input logic r);
    in_valid[i]  = v;
    in_data[i]   = d;
    flush[i]     = f;
    win_ready[i] = r;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    drv(0, 1'b1, 32'h5, 1'b0, 1'b1);
    drv(1, 1'b1, 32'h6, 1'b0, 1'b1);
    tick();
    tick();
    for (int i = 0; i < 2; i++) begin
      chk_cnt++;
      if (in_ready[i] !== 1'b0) $display("FAIL reset_in_ready[%0d]: got %b want 0", i, in_ready[i]);
      else pass_cnt++;
      chk_cnt++;
      if (win_valid[i] !== 1'b0) $display("FAIL reset_win_valid[%0d]: got %b want 0", i, win_valid[i]);
      else pass_cnt++;
      chk_cnt++;
      if (win_data[i] !== '0) $display("FAIL reset_win_data[%0d]: got %h want 0", i, win_data[i]);
      else pass_cnt++;
    end
    drv(0, 1'b0, 32'h0, 1'b0, 1'b1);
    drv(1, 1'b0, 32'h0, 1'b0, 1'b1);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_fill_backpressure();
    win_ready[0] = 1'b1;
    for (int s = 1; s <= 12; s++) begin
      drv(0, 1'b1, 32'(s), 1'b0, 1'b1);
      #1;
      chk_cnt++;
      if (in_ready[0] !== 1'b1) $display("FAIL fill_in_ready s=%0d: got %b want 1", s, in_ready[0]);
      else pass_cnt++;
      tick();
      if (s < 12) begin
        chk_cnt++;
        if (win_valid[0] !== 1'b0) $display("FAIL fill_early_valid s=%0d: got %b want 0", s, win_valid[0]);
        else pass_cnt++;
      end
    end
    chk_cnt++;
    if (win_valid[0] !== 1'b1) $display("FAIL fill_valid: got %b want 1", win_valid[0]);
    else pass_cnt++;
    chk_cnt++;
    if (win_data[0] !== lanes(1)) $display("FAIL fill_data: got %h want %h", win_data[0], lanes(1));
    else pass_cnt++;
    // output stalled, window-completing sample must wait
    drv(0, 1'b1, 32'd13, 1'b0, 1'b0);
    #1;
    chk_cnt++;
    if (in_ready[0] !== 1'b0) $display("FAIL bp_in_ready_low: got %b want 0", in_ready[0]);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (win_valid[0] !== 1'b1 || win_data[0] !== lanes(1))
      $display("FAIL bp_hold: got v=%b d=%h want v=1 d=%h", win_valid[0], win_data[0], lanes(1));
    else pass_cnt++;
    win_ready[0] = 1'b1;
    #1;
    chk_cnt++;
    if (in_ready[0] !== 1'b1) $display("FAIL bp_release_ready: got %b want 1", in_ready[0]);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (win_valid[0] !== 1'b1 || win_data[0] !== lanes(2))
      $display("FAIL bp_next_window: got v=%b d=%h want v=1 d=%h", win_valid[0], win_data[0], lanes(2));
    else pass_cnt++;
    drv(0, 1'b0, 32'd0, 1'b0, 1'b1);
    tick();
    chk_cnt++;
    if (win_valid[0] !== 1'b0) $display("FAIL bp_drain: got %b want 0", win_valid[0]);
    else pass_cnt++;
  endtask

  task automatic test_stride4();
    for (int s = 1; s <= 12; s++) begin
      drv(1, 1'b1, 32'(s), 1'b0, 1'b0);
      tick();
    end
    chk_cnt++;
    if (win_valid[1] !== 1'b1 || win_data[1] !== lanes(1))
      $display("FAIL s4_first: got v=%b d=%h want v=1 d=%h", win_valid[1], win_data[1], lanes(1));
    else pass_cnt++;
    for (int s = 13; s <= 15; s++) begin
      drv(1, 1'b1, 32'(s), 1'b0, 1'b0);
      #1;
      chk_cnt++;
      if (in_ready[1] !== 1'b1) $display("FAIL s4_ready s=%0d: got %b want 1", s, in_ready[1]);
      else pass_cnt++;
      tick();
      chk_cnt++;
      if (win_valid[1] !== 1'b1 || win_data[1] !== lanes(1))
        $display("FAIL s4_hold s=%0d: got v=%b d=%h want v=1 d=%h", s, win_valid[1], win_data[1], lanes(1));
      else pass_cnt++;
    end
    drv(1, 1'b1, 32'd16, 1'b0, 1'b0);
    #1;
    chk_cnt++;
    if (in_ready[1] !== 1'b0) $display("FAIL s4_stall: got %b want 0", in_ready[1]);
    else pass_cnt++;
    tick();
    win_ready[1] = 1'b1;
    #1;
    chk_cnt++;
    if (in_ready[1] !== 1'b1) $display("FAIL s4_release: got %b want 1", in_ready[1]);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (win_valid[1] !== 1'b1 || win_data[1] !== lanes(5))
      $display("FAIL s4_window: got v=%b d=%h want v=1 d=%h", win_valid[1], win_data[1], lanes(5));
    else pass_cnt++;
    drv(1, 1'b0, 32'd0, 1'b0, 1'b1);
    tick();
  endtask

  task automatic test_flush();
    logic [N*32-1:0] pend;
    pend = lanes(3);
    pend[(N-1)*32 +: 32] = 32'd50;
    drv(0, 1'b1, 32'd50, 1'b0, 1'b0);
    tick();
    chk_cnt++;
    if (win_valid[0] !== 1'b1 || win_data[0] !== pend)
      $display("FAIL flush_pending: got v=%b d=%h want v=1 d=%h", win_valid[0], win_data[0], pend);
    else pass_cnt++;
    for (int s = 200; s <= 206; s++) begin
      drv(0, 1'b1, 32'(s), 1'b0, 1'b0);
      tick();
    end
    drv(0, 1'b1, 32'd777, 1'b1, 1'b0);
    #1;
    chk_cnt++;
    if (in_ready[0] !== 1'b0) $display("FAIL flush_ready: got %b want 0", in_ready[0]);
    else pass_cnt++;
    tick();
    for (int s = 100; s <= 110; s++) begin
      drv(0, 1'b1, 32'(s), 1'b0, 1'b0);
      #1;
      chk_cnt++;
      if (in_ready[0] !== 1'b1) $display("FAIL flush_refill_ready s=%0d: got %b want 1", s, in_ready[0]);
      else pass_cnt++;
      tick();
    end
    drv(0, 1'b1, 32'd111, 1'b0, 1'b0);
    #1;
    chk_cnt++;
    if (in_ready[0] !== 1'b0 || win_data[0] !== pend)
      $display("FAIL flush_pending_kept: got r=%b d=%h want r=0 d=%h", in_ready[0], win_data[0], pend);
    else pass_cnt++;
    win_ready[0] = 1'b1;
    tick();
    chk_cnt++;
    if (win_valid[0] !== 1'b1 || win_data[0] !== lanes(100))
      $display("FAIL flush_first_window: got v=%b d=%h want v=1 d=%h", win_valid[0], win_data[0], lanes(100));
    else pass_cnt++;
    drv(0, 1'b0, 32'd0, 1'b0, 1'b1);
    tick();
  endtask

  task automatic test_reset_mid_run();
    for (int s = 17; s <= 20; s++) begin
      drv(1, 1'b1, 32'(s), 1'b0, 1'b0);
      tick();
    end
    chk_cnt++;
    if (win_valid[1] !== 1'b1) $display("FAIL rst_mid_pre_valid: got %b want 1", win_valid[1]);
    else pass_cnt++;
    drv(1, 1'b0, 32'd0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk_cnt++;
    if (in_ready[1] !== 1'b0) $display("FAIL rst_mid_ready: got %b want 0", in_ready[1]);
    else pass_cnt++;
    tick();
    rst = 1'b0;
    chk_cnt++;
    if (win_valid[1] !== 1'b0 || win_data[1] !== '0)
      $display("FAIL rst_mid_clear: got v=%b d=%h want v=0 d=0", win_valid[1], win_data[1]);
    else pass_cnt++;
    for (int s = 300; s <= 311; s++) begin
      drv(1, 1'b1, 32'(s), 1'b0, 1'b1);
      tick();
      if (s < 311) begin
        chk_cnt++;
        if (win_valid[1] !== 1'b0) $display("FAIL rst_mid_early s=%0d: got %b want 0", s, win_valid[1]);
        else pass_cnt++;
      end
    end
    chk_cnt++;
    if (win_valid[1] !== 1'b1 || win_data[1] !== lanes(300))
      $display("FAIL rst_mid_window: got v=%b d=%h want v=1 d=%h", win_valid[1], win_data[1], lanes(300));
    else pass_cnt++;
    drv(1, 1'b0, 32'd0, 1'b0, 1'b1);
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < 2; i++) begin
        drv(i, ($urandom_range(0, 3) != 0), $urandom, ($urandom_range(0, 59) == 0),
            ($urandom_range(0, 2) != 0));
      end
      #1;
      for (int i = 0; i < 2; i++) begin
        chk_cnt++;
        if (in_ready[i] !== m_ready(i))
          $display("FAIL rand_in_ready[%0d] c=%0d: got %b want %b", i, c, in_ready[i], m_ready(i));
        else pass_cnt++;
      end
      tick();
      for (int i = 0; i < 2; i++) begin
        chk_cnt++;
        if (win_valid[i] !== m_valid[i] || win_data[i] !== m_win[i])
          $display("FAIL rand_window[%0d] c=%0d: got v=%b d=%h want v=%b d=%h",
                   i, c, win_valid[i], win_data[i], m_valid[i], m_win[i]);
        else pass_cnt++;
`ifdef MEDIAN_WIN_SEQ_EN
        chk_cnt++;
        if (win_seq[i] !== m_seq[i])
          $display("FAIL rand_seq[%0d] c=%0d: got %h want %h", i, c, win_seq[i], m_seq[i]);
        else pass_cnt++;
`endif
      end
    end
    drv(0, 1'b0, 32'd0, 1'b0, 1'b1);
    drv(1, 1'b0, 32'd0, 1'b0, 1'b1);
    tick();
    tick();
  endtask

`ifdef MEDIAN_WIN_SEQ_EN
  task automatic test_seq();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int s = 1; s <= 14; s++) begin
      drv(0, 1'b1, 32'(s), 1'b0, 1'b1);
      tick();
      if (s >= 12) begin
        chk_cnt++;
        if (win_valid[0] !== 1'b1 || win_seq[0] !== 16'(s - 12))
          $display("FAIL seq_first s=%0d: got v=%b seq=%h want v=1 seq=%h", s, win_valid[0], win_seq[0], 16'(s - 12));
        else pass_cnt++;
      end
    end
    drv(0, 1'b0, 32'd0, 1'b1, 1'b1);
    tick();
    for (int s = 0; s < 12; s++) begin
      drv(0, 1'b1, 32'(s), 1'b0, 1'b1);
      tick();
    end
    chk_cnt++;
    if (win_seq[0] !== 16'd3) $display("FAIL seq_after_flush: got %h want 3", win_seq[0]);
    else pass_cnt++;
    for (int c = 0; c < 65532; c++) tick();
    chk_cnt++;
    if (win_seq[0] !== 16'hFFFF) $display("FAIL seq_top: got %h want ffff", win_seq[0]);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (win_seq[0] !== 16'h0000) $display("FAIL seq_wrap: got %h want 0000", win_seq[0]);
    else pass_cnt++;
    drv(0, 1'b0, 32'd0, 1'b0, 1'b1);
    tick();
  endtask
`endif

  initial begin
    chk_cnt  = 0;
    pass_cnt = 0;
    rst      = 1'b1;
    drv(0, 1'b0, 32'd0, 1'b0, 1'b1);
    drv(1, 1'b0, 32'd0, 1'b0, 1'b1);
    test_reset();
    test_fill_backpressure();
    test_stride4();
    test_flush();
    test_reset_mid_run();
    test_random();
`ifdef MEDIAN_WIN_SEQ_EN
    test_seq();
`endif
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/median_window_loader.md
Name: median_window_loader

Overview:
- Sequential front end for the 12-input median/sort network.
- Accepts a scalar sample stream with a valid/ready handshake and keeps a sliding window of the last N samples.
- Emits a registered parallel window, with its own valid/ready handshake, that drives the network's data_0..data_(N-1) inputs.
- Emits one window every STRIDE accepted samples once the window is full.

Parameters:
- N, 12: window length, equal to the sort network width; legal range 2..64.
- STRIDE, 1: new samples accepted between consecutive windows; legal range 1..N.
- DATA_W, 32: sample width; matches data_t.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  sample present.
- in_data  in  DATA_W  sample value.
- in_ready  out  1  loader can accept a sample this cycle.
- flush  in  1  synchronous restart of window fill (see Behaviour).
- win_valid  out  1  parallel window present.
- win_data  out  N*DATA_W  lane k at [k*DATA_W +: DATA_W]; lane 0 is the oldest sample, lane N-1 the newest.
- win_ready  in  1  downstream takes the window this cycle.

Behaviour:
- Handshakes
  - Accept = in_valid && in_ready.
  - Window transfer = win_valid && win_ready.
- Internal state
  - Shift register sh[0..N-1]; an accept shifts sh[k] <= sh[k+1] and sh[N-1] <= in_data.
  - fill counter 0..N, saturating at N.
  - stride counter 0..STRIDE-1.
- FSM
  - FILL: fill < N. Each accept increments fill. The accept that makes fill = N raises emit, moves to RUN and clears stride.
  - RUN: each accept increments stride. When stride reaches STRIDE-1 on an accept, emit is raised and stride wraps to 0.
  - STRIDE = 1 therefore emits on every accept in RUN.
- Emit
  - Output register loads the post-shift window: the accepted sample appears in lane N-1.
  - win_valid = 1 on the next cycle.
  - Latency: accept at edge t, win_valid and win_data valid after edge t+1; no combinational in->win path.
- Output hold
  - win_valid and win_data are stable until a transfer.
  - On transfer with no same-cycle emit, win_valid goes to 0.
  - Transfer and emit in the same cycle: the new window loads and win_valid stays 1.
- Backpressure
  - in_ready = !(emit_would_occur && win_valid && !win_ready).
  - Loader stalls only when the accept would produce a window while the output register is occupied and not draining.
  - Non-window-completing samples are accepted even while win_valid is stalled.
  - Combinational path win_ready -> in_ready is permitted; no in_valid -> in_ready path.
- Flush
  - fill and stride go to 0 and the FSM goes to FILL; sh contents are don't-care.
  - in_ready = 0 while flush is high; flush takes priority over a same-cycle in_valid.
  - A pending window (win_valid = 1) is kept and still delivered.
- Reset
  - rst = 1: in_ready = 0 during reset, win_valid = 0, win_data = 0, fill = 0, stride = 0, FSM = FILL, sh = 0.
  - Applies mid-operation; any pending window is discarded.
- Width: counters sized $clog2(N+1); no arithmetic on data.

Optional Feature:
- Macro MEDIAN_WIN_SEQ_EN.
- Defined: adds output win_seq, 16 bits, the window sequence number registered alongside win_data.
  - Increments by 1 per emit and wraps 0xFFFF -> 0x0000.
  - rst clears it to 0; flush does not.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package median_pkg holds:
  - data_t (logic [31:0]);
  - localparams MEDIAN_N = 12 and DATA_W = 32;
  - enum win_state_t {FILL, RUN}.
- One sub-module is natural: median_win_shreg (N-deep shift register with enable, parallel read).
- FSM, counters and output register stay in median_window_loader.

Test Plan:
- Fill, STRIDE=1:
  - win_ready=1, in_valid=1, samples 1..12 -> win_valid rises one cycle after the 12th accept, lanes 0..11 = 1..12.
  - Sample 13 -> next window lanes = 2..13.
- Backpressure:
  - Hold win_ready=0 after the first window, then offer sample 13 -> in_ready=0 and the window stays 1..12.
  - Raise win_ready -> same-cycle accept; next window = 2..13 with no gap.
- STRIDE=4 after fill 1..12:
  - Samples 13,14,15 -> no emit; in_ready stays 1 even while window 1..12 is stalled.
  - Sample 16 -> window 5..16.
- Flush:
  - Flush after 7 samples, with in_valid also high that cycle -> sample dropped, in_ready=0.
  - Then samples 100..111 -> first window = 100..111; a window pending at flush is still delivered.
- Reset mid-RUN:
  - rst with win_valid=1 -> next cycle win_valid=0, win_data=0.
  - 11 samples -> no window; 12th -> window.
- MEDIAN_WIN_SEQ_EN defined:
  - 3 windows -> win_seq 0, 1, 2.
  - Force the counter to 0xFFFF -> next win_seq = 0x0000.
  - Flush between windows does not reset the count.
